// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    INIT,
    ARB,
    SEND,
    WAIT
  } sched_state_t;

  // A frame is 10 bit times; the watchdog allows 12 before declaring the UART hung.
  localparam int WDOG_BITS_PER_BYTE = 12;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_byte_t;

  function automatic int wdog_limit(input int clks_per_bit);
    return WDOG_BITS_PER_BYTE * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Rotating priority encoder: first asserted req after index 'last', wrapping.
module rr_pick #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  logic [IW-1:0] idx;

  // Scan farthest-first so the nearest candidate after 'last' overwrites.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one uart_tx between NUM_REQ byte streams,
// with a watchdog that recovers from a transmitter that never signals done.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int CLKS_PER_BIT = 434,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int WDOG_LIMIT = wdog_limit(CLKS_PER_BIT);
  localparam int WW         = $clog2(WDOG_LIMIT + 1);

  sched_state_t           state_q, state_d;
  logic                   lock_q;
  logic [IW-1:0]          last_grant_q;
  logic [IW-1:0]          grant_q;
  tx_byte_t               byte_q;
  logic [WW-1:0]          wdog_q;
  logic                   err_q;
  logic                   lo_seen_q;

  logic [NUM_REQ-1:0][7:0] req_bytes;
  logic [IW-1:0]           pick_idx;
  logic                    pick_any;
  logic [IW-1:0]           win_idx;
  logic                    accept;
  logic                    done_ev;
  logic                    wdog_hit;

  assign req_bytes = req_data;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_valid),
    .last    (last_grant_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // While a packet lock is held only the owner may continue; others wait for release.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    done_ev   = 1'b0;
    wdog_hit  = 1'b0;
    win_idx   = lock_q ? grant_q : pick_idx;
    req_ready = '0;
    case (state_q)
      INIT: if (!tx_active && lo_seen_q) state_d = ARB;
      ARB: begin
        accept = lock_q ? req_valid[grant_q] : pick_any;
        if (accept) state_d = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          done_ev = 1'b1;
          state_d = ARB;
        end else if (wdog_q == WW'(WDOG_LIMIT - 1)) begin
          wdog_hit = 1'b1;
          state_d  = INIT;
        end
      end
      default: state_d = INIT;
    endcase
    req_ready[win_idx] = accept;
  end

  assign tx_start    = (state_q == SEND);
  assign tx_data     = byte_q.data;
  assign grant_id    = grant_q;
  assign busy        = (state_q == SEND) || (state_q == WAIT) || lock_q;
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      lock_q       <= 1'b0;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_q      <= '0;
      byte_q       <= '0;
      wdog_q       <= '0;
      err_q        <= 1'b0;
      lo_seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      // uart_tx has no reset: require two idle cycles so its cleanup cycle has passed.
      lo_seen_q <= (state_q == INIT) && !tx_active;
      wdog_q    <= (state_q == WAIT) ? wdog_q + WW'(1) : '0;
      if (accept) begin
        byte_q.data <= req_bytes[win_idx];
        byte_q.last <= req_last[win_idx];
        grant_q     <= win_idx;
        lock_q      <= 1'b1;
      end
      if (done_ev && byte_q.last) begin
        lock_q       <= 1'b0;
        last_grant_q <= grant_q;
      end
      if (wdog_hit) begin
        err_q  <= 1'b1;
        lock_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural uart_tx and a packet-level RR scoreboard.
module tb_uart_tx_sched;

  localparam int N      = 3;
  localparam int CPB    = 4;
  localparam int PERIOD = 10 * CPB + 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_active;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err_timeout;

  uart_tx_sched #(.NUM_REQ(N), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Requester byte streams: {last, data}
  logic [8:0] mem [N][16];
  int         hd [N];
  int         tl [N];
  logic [N-1:0] pause;
  logic         hang;

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    mem[r][tl[r]] = {l, d};
    tl[r]++;
  endtask

  // Requester driver: pop on handshake, present the next byte after the edge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i] && !rst) hd[i]++;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        req_valid[i]       = !pause[i] && (hd[i] < tl[i]);
        req_data[8*i +: 8] = (hd[i] < tl[i]) ? mem[i][hd[i]][7:0] : 8'h00;
        req_last[i]        = (hd[i] < tl[i]) ? mem[i][hd[i]][8] : 1'b0;
      end
    end
  end

  // Behavioural uart_tx: start seen in cycle s, active s+1..s+41, done pulse in s+42.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !hang) begin
        @(posedge clk);
        #1 tx_active = 1'b1;
        repeat (41) @(posedge clk);
        #1 tx_active = 1'b0;
        tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // Scoreboard: whole packets in round-robin order starting after requester N-1.
  logic [9:0] exp_q [$];
  int         starts [$];
  int         exp_gap;
  int         prev_start;
  int         last_ready_cyc;
  int         ridx;

  task automatic build_exp();
    int h [N];
    int last;
    bit found;
    int r;
    logic [8:0] b;
    h = hd;
    last = N - 1;
    exp_q.delete();
    do begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        r = (last + k) % N;
        if (!found && h[r] < tl[r]) begin
          found = 1;
          while (h[r] < tl[r]) begin
            b = mem[r][h[r]];
            h[r]++;
            exp_q.push_back({2'(r), b[7:0]});
            if (b[8]) break;
          end
          last = r;
        end
      end
    end while (found);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready != '0) begin
          ridx = 0;
          for (int i = 0; i < N; i++) if (req_ready[i]) ridx = i;
          check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
          check("ready_valid", 32'(req_valid[ridx]), 32'd1);
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL ready_unexpected: req_ready=%b with nothing pending", req_ready);
          end else check("ready_owner", 32'(ridx), 32'(exp_q[0][9:8]));
          last_ready_cyc = cyc;
        end
        if (tx_start) begin
          starts.push_back(cyc);
          check("start_after_ready", 32'(cyc - last_ready_cyc), 32'd1);
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL start_unexpected: tx_start with data %0h, nothing pending", tx_data);
          end else begin
            check("tx_data", 32'(tx_data), 32'(exp_q[0][7:0]));
            check("grant_id", 32'(grant_id), 32'(exp_q[0][9:8]));
            void'(exp_q.pop_front());
          end
          if (exp_gap != 0 && prev_start >= 0)
            check("start_period", 32'(cyc - prev_start), 32'(exp_gap));
          prev_start = cyc;
        end
      end
    end
  end

  task automatic reset_begin(input string tag);
    #1 rst = 1'b1;
    pause = '0;
    hang  = 1'b0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    exp_q.delete();
    starts.delete();
    prev_start     = -1;
    last_ready_cyc = -10;
    exp_gap        = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_rst_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_rst_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rst_grant"}, 32'(grant_id), 32'd0);
    check({tag, "_rst_busy"}, 32'(busy), 32'd0);
    check({tag, "_rst_err"}, 32'(err_timeout), 32'd0);
  endtask

  task automatic reset_end(output int rel);
    @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (starts.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (starts.size() < n) begin
      n_chk++;
      $display("FAIL wait_starts: saw %0d of %0d tx_start pulses", starts.size(), n);
    end
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL %s_drain: %0d bytes never sent", tag, exp_q.size());
    end
    repeat (PERIOD + 4) @(posedge clk);
  endtask

  initial begin
    int rel, s, cnt;
    rst = 1'b1;

    // T1: single packet from requester 0
    reset_begin("t1");
    add_byte(0, 8'h55, 1'b0);
    add_byte(0, 8'hA3, 1'b1);
    build_exp();
    exp_gap = PERIOD;
    reset_end(rel);
    wait_starts(2, 300);
    check("t1_first_start", 32'(starts[0] - rel), 32'd3);
    check("t1_gap", 32'(starts[1] - starts[0]), 32'd44);
    at_cycle(starts[1] + 42);
    check("t1_busy_mid", 32'(busy), 32'd1);
    at_cycle(starts[1] + 43);
    check("t1_unlocked", 32'(busy), 32'd0);
    drain("t1", 200);

    // T2: two requesters, 2-byte packets, strict alternation with no switch penalty
    reset_begin("t2");
    add_byte(0, 8'h01, 1'b0); add_byte(0, 8'h02, 1'b1);
    add_byte(0, 8'h03, 1'b0); add_byte(0, 8'h04, 1'b1);
    add_byte(1, 8'h11, 1'b0); add_byte(1, 8'h12, 1'b1);
    add_byte(1, 8'h13, 1'b0); add_byte(1, 8'h14, 1'b1);
    build_exp();
    check("t2_model", 32'({exp_q[1], exp_q[2]}), 32'({2'd0, 8'h02, 2'd1, 8'h11}));
    exp_gap = PERIOD;
    reset_end(rel);
    drain("t2", 8 * PERIOD + 100);

    // T3: all three valid after reset
    reset_begin("t3");
    for (int r = 0; r < N; r++) begin
      add_byte(r, 8'((r << 4) | 1), 1'b1);
      add_byte(r, 8'((r << 4) | 2), 1'b1);
    end
    build_exp();
    check("t3_model", 32'({exp_q[0][9:8], exp_q[1][9:8], exp_q[2][9:8], exp_q[3][7:0]}),
          32'({2'd0, 2'd1, 2'd2, 8'h02}));
    exp_gap = PERIOD;
    reset_end(rel);
    drain("t3", 6 * PERIOD + 100);

    // T4: locked to requester 2 while its valid drops mid-packet
    reset_begin("t4");
    add_byte(0, 8'h01, 1'b1); add_byte(0, 8'h02, 1'b1);
    add_byte(1, 8'h11, 1'b1); add_byte(1, 8'h12, 1'b1);
    add_byte(2, 8'h21, 1'b0); add_byte(2, 8'h22, 1'b0); add_byte(2, 8'h23, 1'b1);
    build_exp();
    reset_end(rel);
    wait_starts(3, 400);
    s = starts[2];
    check("t4_owner", 32'(grant_id), 32'd2);
    at_cycle(s + 20);
    pause[2] = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (req_ready != '0) cnt++;
    end
    check("t4_no_ready_paused", 32'(cnt), 32'd0);
    check("t4_lock_held", 32'(busy), 32'd1);
    pause[2] = 1'b0;
    drain("t4", 8 * PERIOD + 100);

    // T5: reset mid-byte while the UART keeps transmitting
    reset_begin("t5");
    add_byte(0, 8'hA1, 1'b0);
    add_byte(0, 8'hB2, 1'b1);
    build_exp();
    reset_end(rel);
    wait_starts(1, 200);
    s = starts[0];
    at_cycle(s + 10);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_tx_data", 32'(tx_data), 32'd0);
    wait_starts(2, 200);
    check("t5_restart_gap", 32'(starts[1] - s), 32'd45);
    drain("t5", 200);

    // T6: hung transmitter trips the watchdog
    reset_begin("t6");
    hang = 1'b1;
    add_byte(1, 8'h77, 1'b1);
    build_exp();
    reset_end(rel);
    wait_starts(1, 200);
    s = starts[0];
    at_cycle(s + 48);
    check("t6_err_early", 32'(err_timeout), 32'd0);
    at_cycle(s + 49);
    check("t6_err_set", 32'(err_timeout), 32'd1);
    check("t6_unlocked", 32'(busy), 32'd0);
    at_cycle(s + 80);
    check("t6_err_sticky", 32'(err_timeout), 32'd1);
    reset_begin("t6b");
    reset_end(rel);
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL global_timeout: bench did not finish within 20000 cycles");
    $fatal(1);
  end

endmodule
